// File: rtl/led_sequencer_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Mode encoding is visible on the mode output, so the values are fixed.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    ModeRun    = 2'd0,
    ModeBounce = 2'd1,
    ModeCount  = 2'd2,
    ModeHold   = 2'd3
  } mode_e;

  localparam logic [1:0] MODE_RUN    = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  // Pattern value after reset and on entry to RUN/BOUNCE: bit0 lit.
  localparam int unsigned PATTERN_RESET = 1;

  // Each press steps RUN->BOUNCE->COUNT->HOLD and back to RUN.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Tick/button inputs and LED/mode/wrap outputs of the LED sequencer.
// master drives the stimulus side, slave is the sequencer itself.
interface led_sequencer_if #(
  parameter int unsigned LEDS_NR = 3
) ();

  logic               tick;
  logic               btn;
  logic [LEDS_NR-1:0] led;
  logic [1:0]         mode;
  logic               wrap;

  modport master (
    output tick,
    output btn,
    input  led,
    input  mode,
    input  wrap
  );

  modport slave (
    input  tick,
    input  btn,
    output led,
    output mode,
    output wrap
  );

endinterface

// File: rtl/led_sequencer_btn_debounce.sv
// Button synchroniser and debouncer producing a one-cycle press strobe.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module led_sequencer_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_btn_lvl;
  logic [1:0]       r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Polarity fixed ahead of the synchroniser so 1 always means pressed.
  assign w_btn_lvl = (BTN_ACTIVE_LOW != 0) ? ~i_btn_raw : i_btn_raw;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], w_btn_lvl};
      r_press <= 1'b0;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
        r_press  <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: each tick steps the active pattern, a debounced press
// cycles the mode. All outputs are registered in the single clk domain.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int unsigned LEDS_NR         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned LED_ACTIVE_LOW  = 1,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  led_sequencer_if.slave bus
);

  localparam logic [LEDS_NR-1:0] PAT_START = LEDS_NR'(PATTERN_RESET);
  localparam logic [LEDS_NR-1:0] LED_RESET = (LED_ACTIVE_LOW != 0) ? ~PAT_START : PAT_START;

  logic               w_press;
  mode_e              r_mode;
  mode_e              w_mode_d;
  dir_e               r_dir;
  dir_e               w_dir_d;
  logic [LEDS_NR-1:0] r_pattern;
  logic [LEDS_NR-1:0] w_pattern_d;
  logic [LEDS_NR-1:0] r_led;
  logic [LEDS_NR-1:0] w_led_d;
  logic               r_wrap;
  logic               w_wrap_d;

  led_sequencer_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_btn_debounce (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_btn_raw(bus.btn),
    .o_press  (w_press)
  );

  always_comb begin
    w_mode_d    = r_mode;
    w_dir_d     = r_dir;
    w_pattern_d = r_pattern;
    w_wrap_d    = 1'b0;
    // A press takes priority; a tick in the same cycle is dropped.
    if (w_press) begin
      w_mode_d = next_mode(r_mode);
      w_dir_d  = DirUp;
      unique case (w_mode_d)
        ModeRun, ModeBounce: w_pattern_d = PAT_START;
        ModeCount:           w_pattern_d = '0;
        ModeHold:            w_pattern_d = r_pattern;
      endcase
    end else if (bus.tick) begin
      unique case (r_mode)
        ModeRun: begin
          w_pattern_d = {r_pattern[LEDS_NR-2:0], r_pattern[LEDS_NR-1]};
          w_wrap_d    = (w_pattern_d == PAT_START);
        end
        ModeBounce: begin
          // Direction flips on arrival at an end so each endpoint shows once per sweep.
          if (r_dir == DirUp) begin
            w_pattern_d = r_pattern << 1;
            if (w_pattern_d[LEDS_NR-1]) w_dir_d = DirDown;
          end else begin
            w_pattern_d = r_pattern >> 1;
            if (w_pattern_d[0]) begin
              w_dir_d  = DirUp;
              w_wrap_d = 1'b1;
            end
          end
        end
        ModeCount: begin
          w_pattern_d = r_pattern + LEDS_NR'(1);
          w_wrap_d    = (w_pattern_d == '0);
        end
        ModeHold: w_pattern_d = r_pattern;
      endcase
    end
    w_led_d = (LED_ACTIVE_LOW != 0) ? ~w_pattern_d : w_pattern_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode    <= ModeRun;
      r_dir     <= DirUp;
      r_pattern <= PAT_START;
      r_led     <= LED_RESET;
      r_wrap    <= 1'b0;
    end else begin
      r_mode    <= w_mode_d;
      r_dir     <= w_dir_d;
      r_pattern <= w_pattern_d;
      r_led     <= w_led_d;
      r_wrap    <= w_wrap_d;
    end
  end

  assign bus.led  = r_led;
  assign bus.mode = r_mode;
  assign bus.wrap = r_wrap;

endmodule
